freq_gate_ctrl: RTL
===================

# freq_gate_ctrl

Measurement sequencer for the frequency counter. Synchronises an external signal, counts its rising edges over a programmable gate window, converts the count to two BCD digits by sequential subtraction, and pulses `load` so the seven-segment display driver captures `tens`/`units`. It sits between the pad input and the display driver and is the only writer of the display's digit registers.

## Interface
- `PERIOD_W`, 12: width of the gate-length input.
- `COUNT_W`, 7: width of the internal edge counter, which saturates at 2^COUNT_W−1.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset. Clears all state.
- `signal` in 1: raw external signal, asynchronous to `clk`.
- `update_period` in PERIOD_W: gate length in clk cycles. Sampled on entry to COUNT. A value of 0 is treated as 1.
- `tens` out 4: BCD tens digit, 0–9.
- `units` out 4: BCD units digit, 0–9.
- `load` out 1: one-cycle strobe. `tens`/`units` are valid in this cycle.
- `overflow` out 1: high when the last gate counted more than 99 edges. Updated on `load`.
- `busy` out 1: high during conversion states (TENS, UNITS, LOAD).

## Operation
- Input path:
  - `signal` passes through 2 sync flops, then 1 history flop.
  - `edge` = sync_q & ~hist_q. One edge is at most one count per cycle.
- States: COUNT → TENS → UNITS → LOAD → COUNT. Reset state is COUNT.
- COUNT:
  - On entry: timer ← max(`update_period`,1), edge counter ← 0.
  - Each cycle: edge counter increments on `edge`, saturating at 127. Timer decrements.
  - When the timer is 1, the cycle's edge is still counted, then go to TENS.
  - On that transition: rem ← min(count,99) and ovf_next ← (count>99). Counting uses the final count including this cycle's edge.
- TENS:
  - If rem ≥ 10: rem ← rem−10, tens_acc ← tens_acc+1, stay in TENS.
  - Else go to UNITS.
  - tens_acc is cleared on entry.
- UNITS: units_acc ← rem, go to LOAD.
- LOAD:
  - `load`=1 for exactly this cycle.
  - `tens`/`units`/`overflow` output registers take tens_acc/units_acc/ovf_next on the clock edge entering LOAD, so they are valid while `load` is high.
  - Next state is COUNT.
- Output digits hold their value between `load` strobes.
- Edges during TENS/UNITS/LOAD are ignored, not queued. The synchroniser and history flops keep running in every state.
- `update_period` changes mid-gate do not affect the current gate.
- Reset asserted mid-operation:
  - State returns to COUNT. Counters, `tens`, `units`, `overflow`, `load`, `busy` and the sync flops all go to 0.
  - After release, the first gate starts a full `update_period`.

## Timing
- Reset values: `tens`=0, `units`=0, `load`=0, `overflow`=0, `busy`=0.
- Input latency: a `signal` rise is counted 3 clk cycles later (2 sync stages plus the history compare).
- Frame length in cycles = P + (T+1) + 1 + 1, where P = max(`update_period`,1) and T = final tens digit.
  - Maximum conversion length is 12 cycles (T=9).
- `load` never asserts on two consecutive cycles. The minimum spacing is P+3 cycles.
- `busy` is high exactly while in TENS, UNITS or LOAD.
- Saturation boundaries:
  - Count 99 gives 9/9 with overflow 0.
  - Counts 100–127 give 9/9 with overflow 1.
  - The edge counter stops at 127 and does not wrap.

## Structure
- Package `freq_pkg` contains:
  - the state enum `freq_state_t` {COUNT, TENS, UNITS, LOAD};
  - the constants `BCD_MAX`=99, `DIGIT_STEP`=10, `SYNC_STAGES`=2.
- Sub-module `edge_detect`: parameterised synchroniser plus rising-edge pulse, async active-high reset.
- The rest is one FSM with timer, counter and subtractor in `freq_gate_ctrl`.

## Test plan
- Reset release, `update_period`=20, `signal` held low:
  - After 20 cycles in COUNT, expect `load` for one cycle with `tens`=0, `units`=0, `overflow`=0.
  - Expect `busy` high for 3 cycles.
- `update_period`=100, `signal` toggled every 2 clk (25 rises per gate): expect `tens`=2, `units`=5, and 3 TENS cycles before UNITS.
- `update_period`=200, `signal` toggled every clk (100 rises):
  - Expect 9/9 with `overflow`=1.
  - Then set the period so the gate sees exactly 99 rises: expect 9/9 with `overflow`=0.
- `update_period`=0: expect a 1-cycle gate and `load` every 4 cycles, with digits 0/0 and no lockup.
- Change `update_period` from 50 to 10 mid-gate: the current gate still lasts 50 cycles and the next gate lasts 10.
- Assert `reset` during TENS with a count of 57:
  - Expect all outputs 0 immediately (asynchronous) and no `load`.
  - After release, expect a fresh full gate, then `load` with the new count.

Source files
------------

// File: rtl/freq_pkg.sv
// Shared types and constants for the frequency-counter measurement sequencer.
package freq_pkg;

  typedef enum logic [1:0] {
    COUNT,
    TENS,
    UNITS,
    LOAD
  } freq_state_t;

  localparam int BCD_MAX     = 99;
  localparam int DIGIT_STEP  = 10;
  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/edge_detect.sv
// Multi-flop synchroniser for an asynchronous input followed by a history
// flop; emits a one-cycle pulse on each synchronised rising edge.
module edge_detect
  import freq_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES
) (
  input  logic clk,
  input  logic reset,
  input  logic sig_in,
  output logic rise
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              hist_q, hist_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], sig_in};
    hist_d = sync_q[STAGES-1];
  end

  // NOTE: flops use non-blocking assignments so every stage samples the
  // pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign rise = sync_q[STAGES-1] & ~hist_q;

endmodule

// File: rtl/freq_gate_ctrl.sv
// Gate-window edge counter with sequential BCD conversion; strobes load when
// the tens/units digit registers hold a fresh measurement.
module freq_gate_ctrl
  import freq_pkg::*;
#(
  parameter int PERIOD_W = 12,
  parameter int COUNT_W  = 7
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                signal,
  input  logic [PERIOD_W-1:0] update_period,
  output logic [3:0]          tens,
  output logic [3:0]          units,
  output logic                load,
  output logic                overflow,
  output logic                busy
);

  localparam int               REM_W     = 7;
  localparam logic [COUNT_W-1:0] COUNT_SAT = '1;

  freq_state_t         state_q, state_d;
  logic [PERIOD_W-1:0] timer_q, timer_d;
  logic [COUNT_W-1:0]  count_q, count_d;
  logic [REM_W-1:0]    rem_q, rem_d;
  logic [3:0]          tens_acc_q, tens_acc_d;
  logic                ovf_next_q, ovf_next_d;
  logic [3:0]          tens_q, tens_d;
  logic [3:0]          units_q, units_d;
  logic                overflow_q, overflow_d;

  logic                sig_rise;
  logic [PERIOD_W-1:0] timer_eff;
  logic [COUNT_W-1:0]  count_inc;

  edge_detect #(
    .STAGES(SYNC_STAGES)
  ) u_edge_detect (
    .clk   (clk),
    .reset (reset),
    .sig_in(signal),
    .rise  (sig_rise)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    count_d    = count_q;
    rem_d      = rem_q;
    tens_acc_d = tens_acc_q;
    ovf_next_d = ovf_next_q;
    tens_d     = tens_q;
    units_d    = units_q;
    overflow_d = overflow_q;

    // A zero timer marks the first gate cycle: update_period is sampled here.
    timer_eff = (timer_q != '0) ? timer_q
              : ((update_period != '0) ? update_period : PERIOD_W'(1));
    count_inc = (sig_rise && (count_q != COUNT_SAT)) ? count_q + COUNT_W'(1) : count_q;

    unique case (state_q)
      COUNT: begin
        count_d = count_inc;
        if (timer_eff == PERIOD_W'(1)) begin
          state_d    = TENS;
          timer_d    = '0;
          count_d    = '0;
          tens_acc_d = '0;
          if (count_inc > COUNT_W'(BCD_MAX)) begin
            rem_d      = REM_W'(BCD_MAX);
            ovf_next_d = 1'b1;
          end else begin
            rem_d      = REM_W'(count_inc);
            ovf_next_d = 1'b0;
          end
        end else begin
          timer_d = timer_eff - PERIOD_W'(1);
        end
      end
      TENS: begin
        if (rem_q >= REM_W'(DIGIT_STEP)) begin
          rem_d      = rem_q - REM_W'(DIGIT_STEP);
          tens_acc_d = tens_acc_q + 4'd1;
        end else begin
          state_d = UNITS;
        end
      end
      UNITS: begin
        tens_d     = tens_acc_q;
        units_d    = rem_q[3:0];
        overflow_d = ovf_next_q;
        state_d    = LOAD;
      end
      LOAD: begin
        state_d = COUNT;
      end
      default: begin
        state_d = COUNT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= COUNT;
      timer_q    <= '0;
      count_q    <= '0;
      rem_q      <= '0;
      tens_acc_q <= '0;
      ovf_next_q <= 1'b0;
      tens_q     <= '0;
      units_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      count_q    <= count_d;
      rem_q      <= rem_d;
      tens_acc_q <= tens_acc_d;
      ovf_next_q <= ovf_next_d;
      tens_q     <= tens_d;
      units_q    <= units_d;
      overflow_q <= overflow_d;
    end
  end

  assign tens     = tens_q;
  assign units    = units_q;
  assign overflow = overflow_q;
  assign load     = (state_q == LOAD);
  assign busy     = (state_q != COUNT);

endmodule
